// File: rtl/alu_cmd_sequencer.sv
// Command sequencer in front of a combinational ALU: reads operands from a small
// register file, waits SETTLE cycles, captures result/flags, writes back, responds.
// Optional sticky overflow status is built when STICKY_OF_EN is defined.
module alu_cmd_sequencer #(
  parameter int DW     = 8,
  parameter int RA_W   = 2,
  parameter int SETTLE = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_ld,
  input  logic [3:0]      cmd_op,
  input  logic [RA_W-1:0] cmd_rd,
  input  logic [RA_W-1:0] cmd_rs1,
  input  logic [RA_W-1:0] cmd_rs2,
  input  logic [DW-1:0]   cmd_imm,
  output logic [DW-1:0]   alu_a,
  output logic [DW-1:0]   alu_b,
  output logic [3:0]      alu_op,
  input  logic [DW-1:0]   alu_result,
  input  logic            alu_of,
  input  logic            alu_zero,
  input  logic            alu_slt,
  output logic            rsp_valid,
  input  logic            rsp_ready,
  output logic [DW-1:0]   rsp_data,
  output logic            rsp_of,
  output logic            rsp_zero,
  output logic            rsp_slt
`ifdef STICKY_OF_EN
  ,
  input  logic            clr_sticky,
  output logic            ovf_sticky
`endif
);

  localparam int NREG = 1 << RA_W;
  localparam int CW   = (SETTLE > 1) ? $clog2(SETTLE) : 1;

  typedef enum logic [1:0] {IDLE, EXEC, CAPT, RESP} state_t;

  state_t                   state_q, state_d;
  logic [CW-1:0]            cnt_q, cnt_d;
  logic [NREG-1:0][DW-1:0]  rf_q, rf_d;
  logic [RA_W-1:0]          rd_q, rd_d;
  logic [DW-1:0]            a_q, a_d, b_q, b_d;
  logic [3:0]               op_q, op_d;
  logic [DW-1:0]            data_q, data_d;
  logic                     of_q, of_d, zero_q, zero_d, slt_q, slt_d;

  // Gated by rst_n so the block advertises no readiness while held in reset.
  assign cmd_ready = rst_n && (state_q == IDLE);
  assign rsp_valid = (state_q == RESP);
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_op    = op_q;
  assign rsp_data  = data_q;
  assign rsp_of    = of_q;
  assign rsp_zero  = zero_q;
  assign rsp_slt   = slt_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rf_d    = rf_q;
    rd_d    = rd_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    data_d  = data_q;
    of_d    = of_q;
    zero_d  = zero_q;
    slt_d   = slt_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready) begin
          rd_d = cmd_rd;
          if (cmd_ld) begin
            // Immediate load bypasses the ALU; alu_* keep their last values.
            rf_d[cmd_rd] = cmd_imm;
            data_d       = cmd_imm;
            zero_d       = (cmd_imm == '0);
            of_d         = 1'b0;
            slt_d        = 1'b0;
            state_d      = RESP;
          end else begin
            a_d     = rf_q[cmd_rs1];
            b_d     = rf_q[cmd_rs2];
            op_d    = cmd_op;
            cnt_d   = '0;
            state_d = EXEC;
          end
        end
      end
      EXEC: begin
        if (cnt_q == CW'(SETTLE - 1)) state_d = CAPT;
        else                          cnt_d   = cnt_q + 1'b1;
      end
      CAPT: begin
        rf_d[rd_q] = alu_result;
        data_d     = alu_result;
        of_d       = alu_of;
        zero_d     = alu_zero;
        slt_d      = alu_slt;
        state_d    = RESP;
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rf_q    <= '0;
      rd_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= '0;
      data_q  <= '0;
      of_q    <= 1'b0;
      zero_q  <= 1'b0;
      slt_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rf_q    <= rf_d;
      rd_q    <= rd_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      data_q  <= data_d;
      of_q    <= of_d;
      zero_q  <= zero_d;
      slt_q   <= slt_d;
    end
  end

`ifdef STICKY_OF_EN
  logic sticky_q, sticky_d;

  // Set has priority over a simultaneous clear.
  always_comb begin
    sticky_d = sticky_q;
    if (clr_sticky)                      sticky_d = 1'b0;
    if ((state_q == CAPT) && alu_of)     sticky_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sticky_q <= 1'b0;
    else        sticky_q <= sticky_d;
  end

  assign ovf_sticky = sticky_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Directed bench for alu_cmd_sequencer with a behavioural ALU stub on the alu_* side.
module tb_alu_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0, cmd_ready, cmd_ld = 1'b0;
  logic [3:0] cmd_op = '0;
  logic [1:0] cmd_rd = '0, cmd_rs1 = '0, cmd_rs2 = '0;
  logic [7:0] cmd_imm = '0;
  logic [7:0] alu_a, alu_b, alu_result;
  logic [3:0] alu_op;
  logic       alu_of, alu_zero, alu_slt;
  logic       rsp_valid, rsp_ready = 1'b1;
  logic [7:0] rsp_data;
  logic       rsp_of, rsp_zero, rsp_slt;
`ifdef STICKY_OF_EN
  logic       clr_sticky = 1'b0, ovf_sticky;
`endif

  int vecs = 0, errs = 0;
  int lat;
  logic [7:0] c_data, c_a, c_b;
  logic [3:0] c_op;
  logic       c_of, c_zero, c_slt;

  always #5 clk = ~clk;

  alu_cmd_sequencer #(.DW(8), .RA_W(2), .SETTLE(1)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_ld(cmd_ld), .cmd_op(cmd_op),
    .cmd_rd(cmd_rd), .cmd_rs1(cmd_rs1), .cmd_rs2(cmd_rs2), .cmd_imm(cmd_imm),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_result(alu_result),
    .alu_of(alu_of), .alu_zero(alu_zero), .alu_slt(alu_slt),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .rsp_of(rsp_of), .rsp_zero(rsp_zero), .rsp_slt(rsp_slt)
`ifdef STICKY_OF_EN
    , .clr_sticky(clr_sticky), .ovf_sticky(ovf_sticky)
`endif
  );

  // ALU stub: 1001 add, 1010 sub, 0000 and, 0001 or; anything else returns 0.
  always_comb begin
    alu_result = 8'h00;
    alu_of     = 1'b0;
    alu_slt    = 1'b0;
    case (alu_op)
      4'b1001: begin
        alu_result = alu_a + alu_b;
        alu_of  = (alu_a[7] == alu_b[7]) && (alu_result[7] != alu_a[7]);
        alu_slt = $signed(alu_a) < $signed(alu_b);
      end
      4'b1010: begin
        alu_result = alu_a - alu_b;
        alu_of  = (alu_a[7] != alu_b[7]) && (alu_result[7] != alu_a[7]);
        alu_slt = $signed(alu_a) < $signed(alu_b);
      end
      4'b0000: alu_result = alu_a & alu_b;
      4'b0001: alu_result = alu_a | alu_b;
      default: alu_result = 8'h00;
    endcase
    alu_zero = (alu_result == 8'h00);
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    assert (got === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present a command and wait (bounded) for its accept edge.
  task automatic issue(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    int n;
    cmd_ld = ld; cmd_op = op; cmd_rd = rd; cmd_rs1 = rs1; cmd_rs2 = rs2; cmd_imm = imm;
    cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 20) begin tick(); n++; end
    if (!cmd_ready) chk("accept_timeout", 32'd0, 32'd1);
    tick();
    cmd_valid = 1'b0;
  endtask

  // Wait (bounded) for the response, snapshot it, and complete the handshake.
  task automatic get_rsp();
    lat = 0;
    while (!rsp_valid && lat < 20) begin tick(); lat++; end
    if (!rsp_valid) chk("rsp_timeout", 32'd0, 32'd1);
    c_data = rsp_data; c_of = rsp_of; c_zero = rsp_zero; c_slt = rsp_slt;
    c_a = alu_a; c_b = alu_b; c_op = alu_op;
    if (rsp_ready) tick();
  endtask

  task automatic run(input logic ld, input logic [3:0] op, input logic [1:0] rd,
                     input logic [1:0] rs1, input logic [1:0] rs2, input logic [7:0] imm);
    issue(ld, op, rd, rs1, rs2, imm);
    get_rsp();
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_cmd_ready", cmd_ready, 1'b0);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_data", rsp_data, 8'h00);
    chk("rst_alu_op", alu_op, 4'h0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_ready", cmd_ready, 1'b1);

    // 1: loads then add
    run(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h05);
    chk("ld_lat", lat, 0);
    chk("ld_data", c_data, 8'h05);
    run(1'b1, 4'h0, 2'd2, 2'd0, 2'd0, 8'h03);
    run(1'b0, 4'b1001, 2'd3, 2'd1, 2'd2, 8'h00);
    chk("add_lat", lat, 2);
    chk("add_data", c_data, 8'h08);
    chk("add_flags", {c_of, c_zero, c_slt}, 3'b000);
    run(1'b0, 4'b0001, 2'd0, 2'd3, 2'd0, 8'h00);
    chk("r3_readback", c_a, 8'h08);

    // 2: subtract negative and zero results
    run(1'b0, 4'b1010, 2'd3, 2'd2, 2'd1, 8'h00);
    chk("sub_data", c_data, 8'hFE);
    chk("sub_flags", {c_of, c_zero, c_slt}, 3'b001);
    run(1'b0, 4'b1010, 2'd3, 2'd1, 2'd1, 8'h00);
    chk("sub0_data", c_data, 8'h00);
    chk("sub0_zero", c_zero, 1'b1);

    // 3: signed overflow, rd == rs1
    run(1'b1, 4'h0, 2'd0, 2'd0, 2'd0, 8'h7F);
    run(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h01);
    run(1'b0, 4'b1001, 2'd0, 2'd0, 2'd1, 8'h00);
    chk("ovf_data", c_data, 8'h80);
    chk("ovf_of", c_of, 1'b1);
`ifdef STICKY_OF_EN
    chk("sticky_set", ovf_sticky, 1'b1);
    clr_sticky = 1'b1; tick(); clr_sticky = 1'b0;
    chk("sticky_clr", ovf_sticky, 1'b0);
`endif
    run(1'b0, 4'b1001, 2'd2, 2'd0, 2'd3, 8'h00);
    chk("r0_readback", c_a, 8'h80);
    chk("r0_rb_of", c_of, 1'b0);

    // 4: backpressure, queued load only accepted after the response handshake
    rsp_ready = 1'b0;
    issue(1'b0, 4'b1001, 2'd3, 2'd1, 2'd1, 8'h00);
    get_rsp();
    chk("bp_data", c_data, 8'h02);
    cmd_ld = 1'b1; cmd_rd = 2'd2; cmd_imm = 8'h44; cmd_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bp_hold_valid", rsp_valid, 1'b1);
      chk("bp_hold_data", rsp_data, 8'h02);
      chk("bp_cmd_ready", cmd_ready, 1'b0);
    end
    rsp_ready = 1'b1;
    tick();
    chk("bp_released_valid", rsp_valid, 1'b0);
    chk("bp_released_ready", cmd_ready, 1'b1);
    tick();
    cmd_valid = 1'b0;
    chk("bp_ld_valid", rsp_valid, 1'b1);
    chk("bp_ld_data", rsp_data, 8'h44);
    tick();

    // Undefined opcode passes through and writes 0
    run(1'b0, 4'b1100, 2'd3, 2'd2, 2'd1, 8'h00);
    chk("undef_op", c_op, 4'hC);
    chk("undef_data", c_data, 8'h00);
    chk("undef_zero", c_zero, 1'b1);

    // 6: load zero immediate
    run(1'b1, 4'h5, 2'd1, 2'd0, 2'd0, 8'h00);
    chk("ld0_lat", lat, 0);
    chk("ld0_zero", c_zero, 1'b1);
    chk("ld0_alu_op", c_op, 4'hC);

    // 5: reset pulse during EXEC aborts the command and clears the register file
    run(1'b1, 4'h0, 2'd1, 2'd0, 2'd0, 8'h11);
    issue(1'b0, 4'b1001, 2'd3, 2'd1, 2'd2, 8'h00);
    rst_n = 1'b0;
    #2;
    chk("exec_rst_ready", cmd_ready, 1'b0);
    chk("exec_rst_alu_a", alu_a, 8'h00);
    rst_n = 1'b1;
    tick();
    chk("exec_rst_ready_after", cmd_ready, 1'b1);
    for (int i = 0; i < 4; i++) begin
      chk("exec_rst_no_rsp", rsp_valid, 1'b0);
      tick();
    end
    run(1'b0, 4'b1001, 2'd0, 2'd1, 2'd2, 8'h00);
    chk("rf_clr_a", {c_a, c_b}, 16'h0000);
    chk("rf_clr_data", c_data, 8'h00);
    run(1'b0, 4'b1001, 2'd0, 2'd3, 2'd0, 8'h00);
    chk("rf_clr_a2", {c_a, c_b}, 16'h0000);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
